// File: rtl/product_accumulator_64b.sv
// Sums a programmed number of unsigned products received over valid/ready and
// presents the total over an output valid/ready handshake. Optional macro: SATURATE_EN.
module product_accumulator_64b #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned ACC_W  = 72,
    parameter int unsigned LEN_W  = 8
) (
    input  logic              iClk,
    input  logic              iRst,
    input  logic              iClr,
    input  logic              iStart,
    input  logic [LEN_W-1:0]  iLen,
    input  logic              iValid,
    input  logic [DATA_W-1:0] iData,
    output logic              oReady,
    output logic              oValid,
    input  logic              iReady,
    output logic [ACC_W-1:0]  oData,
    output logic              oBusy,
`ifdef SATURATE_EN
    output logic              oOvf,
`endif
    output logic [LEN_W-1:0]  oCount
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StAcc  = 2'd1;
    localparam logic [1:0] StDone = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [ACC_W-1:0] data_q, data_d;
    logic [LEN_W-1:0] count_q, count_d;
    logic [ACC_W-1:0] acc_next;

`ifdef SATURATE_EN
    logic             ovf_q, ovf_d;
    logic [ACC_W:0]   sum;

    // Carry out of the accumulator clamps it to all-ones and latches the flag.
    always_comb begin
        sum   = {1'b0, acc_q} + (ACC_W+1)'(iData);
        ovf_d = ovf_q;
        if (sum[ACC_W]) begin
            acc_next = '1;
        end else begin
            acc_next = sum[ACC_W-1:0];
        end
        if (state_q == StAcc && iValid && sum[ACC_W]) begin
            ovf_d = 1'b1;
        end
        if (state_q == StIdle && iStart) begin
            ovf_d = 1'b0;
        end
        if (iClr) begin
            ovf_d = 1'b0;
        end
    end

    assign oOvf = ovf_q;
`else
    always_comb begin
        acc_next = acc_q + ACC_W'(iData);
    end
`endif

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        data_d  = data_q;
        count_d = count_q;
        case (state_q)
            StIdle: begin
                if (iStart) begin
                    if (iLen != '0) begin
                        state_d = StAcc;
                        acc_d   = '0;
                        count_d = iLen;
                    end else begin
                        state_d = StDone;
                        data_d  = '0;
                        count_d = '0;
                    end
                end
            end
            StAcc: begin
                if (iValid) begin
                    acc_d   = acc_next;
                    count_d = count_q - LEN_W'(1);
                    if (count_q == LEN_W'(1)) begin
                        state_d = StDone;
                        data_d  = acc_next;
                    end
                end
            end
            StDone: begin
                // A start on this exit edge is dropped: the case only looks at iStart in StIdle.
                if (iReady) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
        if (iClr) begin
            state_d = StIdle;
            acc_d   = '0;
            data_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_q <= StIdle;
            acc_q   <= '0;
            data_q  <= '0;
            count_q <= '0;
`ifdef SATURATE_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            data_q  <= data_d;
            count_q <= count_d;
`ifdef SATURATE_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign oReady = (state_q == StAcc);
    assign oValid = (state_q == StDone);
    assign oBusy  = (state_q != StIdle);
    assign oData  = data_q;
    assign oCount = count_q;

endmodule

// File: tb/tb_product_accumulator_64b.sv
// Directed bench for product_accumulator_64b built with a 64-bit accumulator so the
// wrap/saturate boundary is reachable; honours SATURATE_EN when defined.
module tb_product_accumulator_64b;

    localparam int unsigned DATA_W = 64;
    localparam int unsigned ACC_W  = 64;
    localparam int unsigned LEN_W  = 8;

    logic              iClk;
    logic              iRst;
    logic              iClr;
    logic              iStart;
    logic [LEN_W-1:0]  iLen;
    logic              iValid;
    logic [DATA_W-1:0] iData;
    logic              oReady;
    logic              oValid;
    logic              iReady;
    logic [ACC_W-1:0]  oData;
    logic              oBusy;
    logic [LEN_W-1:0]  oCount;
`ifdef SATURATE_EN
    logic              oOvf;
`endif

    int tests;
    int fails;

    product_accumulator_64b #(
        .DATA_W(DATA_W),
        .ACC_W (ACC_W),
        .LEN_W (LEN_W)
    ) dut (
        .iClk  (iClk),
        .iRst  (iRst),
        .iClr  (iClr),
        .iStart(iStart),
        .iLen  (iLen),
        .iValid(iValid),
        .iData (iData),
        .oReady(oReady),
        .oValid(oValid),
        .iReady(iReady),
        .oData (oData),
        .oBusy (oBusy),
`ifdef SATURATE_EN
        .oOvf  (oOvf),
`endif
        .oCount(oCount)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    task automatic tick();
        @(posedge iClk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic feed(input logic [63:0] d);
        iValid = 1'b1;
        iData  = d;
        tick();
        iValid = 1'b0;
    endtask

    task automatic start(input logic [LEN_W-1:0] n);
        iStart = 1'b1;
        iLen   = n;
        tick();
        iStart = 1'b0;
    endtask

    initial begin
        tests  = 0;
        fails  = 0;
        iRst   = 1'b1;
        iClr   = 1'b0;
        iStart = 1'b0;
        iLen   = '0;
        iValid = 1'b0;
        iData  = '0;
        iReady = 1'b0;
        tick();
        tick();
        iRst = 1'b0;

        // Reset state
        chk("rst_ready", 64'(oReady), 64'd0);
        chk("rst_valid", 64'(oValid), 64'd0);
        chk("rst_busy",  64'(oBusy),  64'd0);
        chk("rst_data",  oData,       64'd0);
        chk("rst_count", 64'(oCount), 64'd0);
`ifdef SATURATE_EN
        chk("rst_ovf",   64'(oOvf),   64'd0);
`endif

        // 1: four back-to-back terms
        start(8'd4);
        chk("t1_busy",  64'(oBusy),  64'd1);
        chk("t1_ready", 64'(oReady), 64'd1);
        chk("t1_count", 64'(oCount), 64'd4);
        feed(64'd3);
        feed(64'd5);
        feed(64'd7);
        chk("t1_count1", 64'(oCount), 64'd1);
        chk("t1_novalid", 64'(oValid), 64'd0);
        feed(64'd9);
        chk("t1_valid",  64'(oValid), 64'd1);
        chk("t1_data",   oData,       64'd24);
        chk("t1_count0", 64'(oCount), 64'd0);
        chk("t1_dready", 64'(oReady), 64'd0);
        iReady = 1'b1;
        tick();
        iReady = 1'b0;
        chk("t1_idle", 64'(oBusy), 64'd0);

        // 2: gapped valid
        start(8'd3);
        feed(64'd10);
        iData = 64'd99;
        tick();
        chk("t2_hold", 64'(oCount), 64'd2);
        feed(64'd20);
        iData = 64'd99;
        tick();
        feed(64'd30);
        chk("t2_valid", 64'(oValid), 64'd1);
        chk("t2_data",  oData,       64'd60);
        chk("t2_ready", 64'(oReady), 64'd0);

        // 3: result backpressure with stray iValid
        for (int i = 0; i < 5; i++) begin
            iValid = 1'b1;
            iData  = 64'd1000;
            tick();
            chk("t3_valid", 64'(oValid), 64'd1);
            chk("t3_data",  oData,       64'd60);
            chk("t3_count", 64'(oCount), 64'd0);
        end
        iValid = 1'b0;
        iReady = 1'b1;
        iStart = 1'b1;
        iLen   = 8'd2;
        tick();
        iReady = 1'b0;
        iStart = 1'b0;
        chk("t3_exit_busy", 64'(oBusy), 64'd0);
        tick();
        chk("t3_start_ignored", 64'(oBusy), 64'd0);

        // 4: zero-length job, then start during ACC
        start(8'd0);
        chk("t4_valid", 64'(oValid), 64'd1);
        chk("t4_data",  oData,       64'd0);
        iReady = 1'b1;
        tick();
        iReady = 1'b0;
        start(8'd3);
        iStart = 1'b1;
        iLen   = 8'd7;
        tick();
        iStart = 1'b0;
        chk("t4_count", 64'(oCount), 64'd3);
        feed(64'd1);
        feed(64'd2);
        feed(64'd3);
        chk("t4_data6", oData, 64'd6);
        iReady = 1'b1;
        tick();
        iReady = 1'b0;

        // 5: clear and reset mid-job
        start(8'd4);
        feed(64'd5);
        feed(64'd6);
        iClr = 1'b1;
        tick();
        iClr = 1'b0;
        chk("t5_clr_busy",  64'(oBusy),  64'd0);
        chk("t5_clr_data",  oData,       64'd0);
        chk("t5_clr_count", 64'(oCount), 64'd0);
        start(8'd3);
        feed(64'd100);
        iRst = 1'b1;
        tick();
        iRst = 1'b0;
        chk("t5_rst_busy",  64'(oBusy),  64'd0);
        chk("t5_rst_count", 64'(oCount), 64'd0);
        start(8'd2);
        feed(64'd4);
        feed(64'd5);
        chk("t5_resum", oData, 64'd9);
        iReady = 1'b1;
        tick();
        iReady = 1'b0;

        // 6: overflow boundary
        start(8'd2);
        feed(64'hFFFF_FFFF_FFFF_FFFF);
        feed(64'd2);
        chk("t6_valid", 64'(oValid), 64'd1);
`ifdef SATURATE_EN
        chk("t6_sat",   oData,      64'hFFFF_FFFF_FFFF_FFFF);
        chk("t6_ovf",   64'(oOvf),  64'd1);
`else
        chk("t6_wrap",  oData,      64'd1);
`endif
        iReady = 1'b1;
        tick();
        iReady = 1'b0;
`ifdef SATURATE_EN
        chk("t6_ovf_idle", 64'(oOvf), 64'd1);
`endif
        start(8'd1);
`ifdef SATURATE_EN
        chk("t6_ovf_clr", 64'(oOvf), 64'd0);
`endif
        feed(64'd7);
        chk("t6_next", oData, 64'd7);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
